// File: rtl/qproc_time_dispatch.sv
// qproc_time_dispatch
// Timestamped event dispatcher. Commands {time, data} are buffered in order in
// a FIFO. The oldest command is moved into a head register and compared every
// cycle against the absolute time. When the time is reached, a registered
// one-cycle event is emitted.
//
// Build option:
//   QPROC_TIME_DISPATCH_LATE_DROP_EN - when defined, late hits are dropped:
//   evt_valid_o stays low and evt_late_o pulses alone, with evt_time_o and
//   evt_data_o updated.
//
// Ports:
//   t_clk_i, t_rst_ni            time clock, asynchronous active-low reset
//   time_abs_i [47:0]            current absolute time
//   flush_i                      synchronous clear of FIFO and head
//   cmd_valid_i/cmd_ready_o      command handshake
//   cmd_time_i [47:0]            scheduled time of the command
//   cmd_data_i [DW-1:0]          command payload
//   evt_valid_o, evt_late_o      registered event pulse and late flag
//   evt_time_o, evt_data_o       time and payload of the last event
//   fifo_cnt_o                   FIFO occupancy, excluding the head register
//   fifo_full_o, fifo_empty_o    FIFO status
module qproc_time_dispatch #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                   t_clk_i,
  input  logic                   t_rst_ni,
  input  logic [47:0]            time_abs_i,
  input  logic                   flush_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [47:0]            cmd_time_i,
  input  logic [DW-1:0]          cmd_data_i,
  output logic                   evt_valid_o,
  output logic                   evt_late_o,
  output logic [47:0]            evt_time_o,
  output logic [DW-1:0]          evt_data_o,
  output logic [$clog2(DEPTH):0] fifo_cnt_o,
  output logic                   fifo_full_o,
  output logic                   fifo_empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 48 + DW;

  // The head register holds a valid entry exactly while in ST_WAIT.
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FIRE} state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [47:0]   head_time_q, head_time_d;
  logic [DW-1:0] head_data_q, head_data_d;
  logic          evt_valid_q, evt_valid_d;
  logic          evt_late_q, evt_late_d;
  logic [47:0]   evt_time_q, evt_time_d;
  logic [DW-1:0] evt_data_q, evt_data_d;

  logic          push;
  logic          pop;
  logic          hit;
  logic          late;
  logic [47:0]   diff;
  logic [EW-1:0] rd_entry;

  assign cmd_ready_o  = (cnt_q != CW'(DEPTH)) && !flush_i;
  assign push         = cmd_valid_i && cmd_ready_o;
  assign rd_entry     = mem_q[rd_ptr_q];

  // Modular difference read as signed: bit 47 clear means the scheduled time
  // has been reached or passed, which stays correct across the 48-bit wrap.
  assign diff = time_abs_i - head_time_q;
  assign hit  = !diff[47];
  assign late = |diff;

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    head_time_d = head_time_q;
    head_data_d = head_data_q;
    evt_valid_d = 1'b0;
    evt_late_d  = 1'b0;
    evt_time_d  = evt_time_q;
    evt_data_d  = evt_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (hit) begin
          evt_time_d = head_time_q;
          evt_data_d = head_data_q;
          evt_late_d = late;
`ifdef QPROC_TIME_DISPATCH_LATE_DROP_EN
          evt_valid_d = !late;
`else
          evt_valid_d = 1'b1;
`endif
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over a concurrent hit or pop; the last event payload is kept.
    if (flush_i) begin
      state_d     = ST_IDLE;
      pop         = 1'b0;
      evt_valid_d = 1'b0;
      evt_late_d  = 1'b0;
      evt_time_d  = evt_time_q;
      evt_data_d  = evt_data_q;
    end

    if (pop) begin
      head_time_d = rd_entry[EW-1:DW];
      head_data_d = rd_entry[DW-1:0];
    end

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      head_time_q <= '0;
      head_data_q <= '0;
      evt_valid_q <= 1'b0;
      evt_late_q  <= 1'b0;
      evt_time_q  <= '0;
      evt_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      head_time_q <= head_time_d;
      head_data_q <= head_data_d;
      evt_valid_q <= evt_valid_d;
      evt_late_q  <= evt_late_d;
      evt_time_q  <= evt_time_d;
      evt_data_q  <= evt_data_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge t_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_time_i, cmd_data_i};
    end
  end

  assign evt_valid_o  = evt_valid_q;
  assign evt_late_o   = evt_late_q;
  assign evt_time_o   = evt_time_q;
  assign evt_data_o   = evt_data_q;
  assign fifo_cnt_o   = cnt_q;
  assign fifo_full_o  = (cnt_q == CW'(DEPTH));
  assign fifo_empty_o = (cnt_q == '0);

endmodule

// File: tb/tb_qproc_time_dispatch.sv
`timescale 1ns/1ps
module tb_qproc_time_dispatch;
  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = 2 + 48 + DW + CW + 3;
`ifdef QPROC_TIME_DISPATCH_LATE_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [47:0]   time_abs = '0;
  logic          flush = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready_o;
  logic [47:0]   cmd_time = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          evt_valid_o, evt_late_o;
  logic [47:0]   evt_time_o;
  logic [DW-1:0] evt_data_o;
  logic [CW-1:0] fifo_cnt_o;
  logic          fifo_full_o, fifo_empty_o;
  logic [VW-1:0] obs_vec;

  always #5 clk = ~clk;

  qproc_time_dispatch #(.DEPTH(DEPTH), .DW(DW)) dut (
    .t_clk_i(clk), .t_rst_ni(rst_n), .time_abs_i(time_abs), .flush_i(flush),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_time_i(cmd_time),
    .cmd_data_i(cmd_data), .evt_valid_o(evt_valid_o), .evt_late_o(evt_late_o),
    .evt_time_o(evt_time_o), .evt_data_o(evt_data_o), .fifo_cnt_o(fifo_cnt_o),
    .fifo_full_o(fifo_full_o), .fifo_empty_o(fifo_empty_o)
  );

  assign obs_vec = {evt_valid_o, evt_late_o, evt_time_o, evt_data_o,
                    fifo_cnt_o, fifo_full_o, fifo_empty_o, cmd_ready_o};

  // Reference model: every accepted command remembers its accept cycle (a)
  // and the first cycle it is compared against time (s, -1 while it still
  // waits behind an older command). A command enters comparison two cycles
  // after it is accepted or two cycles after its predecessor hits, whichever
  // is later; it occupies the FIFO from a+1 until s-1.
  typedef struct {
    logic [47:0]   t;
    logic [DW-1:0] d;
    int            a;
    int            s;
  } ent_t;

  ent_t          q[$];
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  logic          m_valid, m_late, m_ready;
  logic [47:0]   m_time;
  logic [DW-1:0] m_data;
  logic [VW-1:0] exp_vec;

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_late  = 1'b0;
    m_time  = '0;
    m_data  = '0;
  endtask

  // Let inputs settle and compute the expected outputs of the current cycle.
  task automatic settle();
    int n;
    #1;
    n = 0;
    foreach (q[i]) if (q[i].a < cyc && (q[i].s < 0 || cyc < q[i].s)) n++;
    m_ready = (n != DEPTH) && !flush;
    exp_vec = {m_valid, m_late, m_time, m_data, CW'(n), (n == DEPTH), (n == 0), m_ready};
  endtask

  // Apply the current cycle's inputs to the model, then cross the clock edge.
  task automatic advance();
    logic [47:0] diff;
    logic        nv, nl, lt;
    ent_t        e;
    nv = 1'b0;
    nl = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].s >= 0 && q[0].s <= cyc) begin
        diff = time_abs - q[0].t;
        if (!diff[47]) begin
          lt     = (diff != 48'd0);
          nv     = DROP ? !lt : 1'b1;
          nl     = lt;
          m_time = q[0].t;
          m_data = q[0].d;
          $display("event cyc=%0d time=%h data=%h late=%0d", cyc + 1, m_time, m_data, lt);
          void'(q.pop_front());
          if (q.size() > 0) q[0].s = cyc + 2;
        end
      end
      if (cmd_valid && m_ready) begin
        e.t = cmd_time;
        e.d = cmd_data;
        e.a = cyc;
        e.s = (q.size() == 0) ? cyc + 2 : -1;
        q.push_back(e);
        $display("push  cyc=%0d time=%h data=%h", cyc, cmd_time, cmd_data);
      end
    end
    m_valid = nv;
    m_late  = nl;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic release_reset();
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc += 2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    flush = 1'b0;
    time_abs = '0;
    @(posedge clk);
    #1;
    model_reset();
    settle();
    checks++;
    if (obs_vec !== {2'b00, 48'd0, 32'd0, CW'(0), 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_values got=%h exp=%h", obs_vec, {2'b00, 48'd0, 32'd0, CW'(0), 1'b0, 1'b1, 1'b1});
    end
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL reset_model got=%h exp=%h", obs_vec, exp_vec);
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_basic();
    int np, pk;
    logic [DW-1:0] pd;
    logic pl;
    np = 0; pk = -1; pd = '0; pl = 1'b1;
    for (int k = 0; k < 112; k++) begin
      time_abs = 48'(k);
      cmd_valid = (k == 0);
      cmd_time = 48'd100;
      cmd_data = 32'hA5;
      settle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (evt_valid_o) begin np++; pk = k; pd = evt_data_o; pl = evt_late_o; end
      advance();
    end
    cmd_valid = 1'b0;
    checks++;
    if (np != 1 || pk != 101 || pd !== 32'hA5 || pl !== 1'b0) begin
      errors++;
      $display("FAIL basic_event got pulses=%0d at=%0d data=%h late=%b exp pulses=1 at=101 data=a5 late=0", np, pk, pd, pl);
    end
  endtask

  task automatic test_late();
    logic [1:0] exp2;
    exp2 = DROP ? 2'b01 : 2'b11;
    time_abs = 48'd500;
    for (int k = 0; k < 6; k++) begin
      cmd_valid = (k == 0);
      cmd_time = 48'd10;
      cmd_data = $urandom;
      settle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL late cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (k == 3) begin
        checks++;
        if ({evt_valid_o, evt_late_o} !== exp2) begin
          errors++;
          $display("FAIL late_pulse got valid/late=%b exp=%b", {evt_valid_o, evt_late_o}, exp2);
        end
      end
      advance();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int np, lastk, gap_bad;
    logic [DW-1:0] exp_d;
    time_abs = '0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      cmd_valid = 1'b1;
      cmd_time = 48'd1000 + 48'(k);
      cmd_data = DW'(k);
      settle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL fill cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (k == DEPTH + 1) begin
        checks++;
        if ({cmd_ready_o, fifo_full_o, fifo_cnt_o} !== {1'b0, 1'b1, CW'(DEPTH)}) begin
          errors++;
          $display("FAIL full_state got ready/full/cnt=%b/%b/%0d exp 0/1/%0d", cmd_ready_o, fifo_full_o, fifo_cnt_o, DEPTH);
        end
      end
      advance();
    end
    cmd_valid = 1'b0;
    time_abs = 48'd5000;
    np = 0; lastk = -10; gap_bad = 0; exp_d = '0;
    for (int k = 0; k < 2 * DEPTH + 8; k++) begin
      settle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (evt_valid_o || evt_late_o) begin
        checks++;
        if (evt_data_o !== exp_d) begin
          errors++;
          $display("FAIL drain_order got data=%h exp=%h", evt_data_o, exp_d);
        end
        if (np > 0 && k - lastk != 2) gap_bad++;
        exp_d++; np++; lastk = k;
      end
      advance();
    end
    checks++;
    if (np != DEPTH + 1 || gap_bad != 0) begin
      errors++;
      $display("FAIL drain_rate got events=%0d bad_gaps=%0d exp events=%0d bad_gaps=0", np, gap_bad, DEPTH + 1);
    end
  endtask

  task automatic test_wrap();
    int np, pk;
    logic pl;
    np = 0; pk = -1; pl = 1'b1;
    for (int k = 0; k < 14; k++) begin
      time_abs = 48'hFFFF_FFFF_FFFE + 48'(k);
      cmd_valid = (k == 0);
      cmd_time = 48'd5;
      cmd_data = $urandom;
      settle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (evt_valid_o || evt_late_o) begin np++; pk = k; pl = evt_late_o; end
      advance();
    end
    cmd_valid = 1'b0;
    checks++;
    if (np != 1 || pk != 8 || pl !== 1'b0) begin
      errors++;
      $display("FAIL wrap_event got pulses=%0d at=%0d late=%b exp pulses=1 at=8 late=0", np, pk, pl);
    end
  endtask

  task automatic test_flush();
    int np;
    np = 0;
    time_abs = '0;
    for (int k = 0; k < 30; k++) begin
      cmd_valid = (k < 4);
      cmd_time = 48'd50 + 48'(10 * k);
      cmd_data = $urandom;
      flush = (k == 8);
      if (k >= 8) time_abs = 48'd50 + 48'(k - 8);
      settle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL flush cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (k == 8) begin
        checks++;
        if ({cmd_ready_o, fifo_cnt_o} !== {1'b0, CW'(3)}) begin
          errors++;
          $display("FAIL flush_cycle got ready/cnt=%b/%0d exp 0/3", cmd_ready_o, fifo_cnt_o);
        end
      end
      if (k == 9) begin
        checks++;
        if ({cmd_ready_o, fifo_cnt_o} !== {1'b1, CW'(0)}) begin
          errors++;
          $display("FAIL after_flush got ready/cnt=%b/%0d exp 1/0", cmd_ready_o, fifo_cnt_o);
        end
      end
      if (k > 8 && (evt_valid_o || evt_late_o)) np++;
      advance();
    end
    cmd_valid = 1'b0;
    flush = 1'b0;
    checks++;
    if (np != 0) begin
      errors++;
      $display("FAIL flush_events got=%0d exp=0", np);
    end
  endtask

  task automatic test_random();
    logic [47:0] tcur;
    tcur = 48'd20000;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 49) == 0) tcur = tcur - 48'($urandom_range(0, 30));
      else tcur = tcur + 48'($urandom_range(0, 3));
      time_abs = tcur;
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_time = tcur + 48'($urandom_range(0, 80)) - 48'd20;
      cmd_data = $urandom;
      flush = ($urandom_range(0, 99) == 0);
      settle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      advance();
    end
    cmd_valid = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < 4 * DEPTH + 8; k++) begin
      time_abs = time_abs + 48'd200;
      settle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    int np;
    np = 0;
    time_abs = '0;
    for (int k = 0; k < 5; k++) begin
      cmd_valid = (k == 0);
      cmd_time = 48'd1000;
      cmd_data = $urandom;
      settle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL areset_pre cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (k < 4) advance();
    end
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec !== {2'b00, 48'd0, 32'd0, CW'(0), 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL areset_wait got=%h exp=%h", obs_vec, {2'b00, 48'd0, 32'd0, CW'(0), 1'b0, 1'b1, 1'b1});
    end
    release_reset();
    time_abs = 48'd2000;
    for (int k = 0; k < 10; k++) begin
      settle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL areset_post cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (evt_valid_o || evt_late_o) np++;
      advance();
    end
    checks++;
    if (np != 0) begin
      errors++;
      $display("FAIL areset_no_event got=%0d exp=0", np);
    end
    // Second pass: reset lands while the event pulse is high.
    for (int k = 0; k < 4; k++) begin
      cmd_valid = (k == 0);
      cmd_time = 48'd1500;
      cmd_data = $urandom;
      settle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL areset_fire cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (k < 3) advance();
    end
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec !== {2'b00, 48'd0, 32'd0, CW'(0), 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL areset_in_fire got=%h exp=%h", obs_vec, {2'b00, 48'd0, 32'd0, CW'(0), 1'b0, 1'b1, 1'b1});
    end
    release_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_late();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
